// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI byte stream to register bus bridge with idle timeout abort
// Define SPI_REG_BRIDGE_AUTOINC_EN to advance the address after every register strobe.
module spi_reg_bridge #(
  parameter int TIMEOUT_CYCLES = 27000,
  parameter int TIMEOUT_WIDTH  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       timeout_pulse
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LEN      = 3'd1;
  localparam logic [2:0] S_WDATA    = 3'd2;
  localparam logic [2:0] S_RSTROBE  = 3'd3;
  localparam logic [2:0] S_RCAPTURE = 3'd4;
  localparam logic [2:0] S_RSEND    = 3'd5;

  logic [2:0]               state_q, state_d;
  logic                     rw_q, rw_d;
  logic [6:0]               addr_q, addr_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [7:0]               wdata_q, wdata_d;
  logic                     we_q, we_d;
  logic [7:0]               txd_q, txd_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic                     tpulse_q, tpulse_d;
  logic                     rx_xfer, tx_xfer, expired;

  assign rx_ready      = 1'b1;
  assign rx_xfer       = rx_valid && rx_ready;
  assign tx_valid      = (state_q == S_RSEND);
  assign tx_xfer       = tx_valid && tx_ready;
  assign reg_re        = (state_q == S_RSTROBE);
  assign reg_we        = we_q;
  assign reg_addr      = addr_q;
  assign reg_wdata     = wdata_q;
  assign tx_data       = txd_q;
  assign busy          = (state_q != S_IDLE);
  assign timeout_pulse = tpulse_q;

  // Any handshake in the expiry cycle keeps the transaction alive.
  assign expired = busy && (tmo_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)) && !rx_xfer && !tx_xfer;

  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    txd_d    = txd_q;
    tpulse_d = 1'b0;

    if (state_q == S_IDLE || rx_xfer || tx_xfer) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
    end

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
    // The address moves only after its strobe cycle so reg_addr is valid alongside the strobe.
    if (we_q || reg_re) begin
      addr_d = addr_q + 7'd1;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (rx_xfer) begin
          rw_d    = rx_data[7];
          addr_d  = rx_data[6:0];
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_xfer) begin
          cnt_d = rx_data;
          if (rx_data == 8'd0) begin
            state_d = S_IDLE;
          end else if (rw_q) begin
            state_d = S_WDATA;
          end else begin
            state_d = S_RSTROBE;
          end
        end
      end
      S_WDATA: begin
        if (rx_xfer) begin
          we_d    = 1'b1;
          wdata_d = rx_data;
          cnt_d   = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = S_IDLE;
          end
        end
      end
      S_RSTROBE: begin
        state_d = S_RCAPTURE;
      end
      S_RCAPTURE: begin
        txd_d   = reg_rdata;
        state_d = S_RSEND;
      end
      S_RSEND: begin
        if (tx_xfer) begin
          cnt_d   = cnt_q - 8'd1;
          state_d = (cnt_q == 8'd1) ? S_IDLE : S_RSTROBE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (expired) begin
      state_d  = S_IDLE;
      tmo_d    = '0;
      tpulse_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rw_q     <= 1'b0;
      addr_q   <= 7'd0;
      cnt_q    <= 8'd0;
      wdata_q  <= 8'd0;
      we_q     <= 1'b0;
      txd_q    <= 8'd0;
      tmo_q    <= '0;
      tpulse_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      txd_q    <= txd_d;
      tmo_q    <= tmo_d;
      tpulse_q <= tpulse_d;
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb/tb_spi_reg_bridge.sv - directed table, corner sequences and randomized transactions for spi_reg_bridge
module tb_spi_reg_bridge;

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'd0;
  logic       busy;
  logic       timeout_pulse;

  spi_reg_bridge #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_tmo = 0;

  logic [14:0] got_wr[$];
  logic [14:0] exp_wr[$];
  logic [6:0]  got_rd[$];
  logic [6:0]  exp_rd[$];
  logic [7:0]  got_tx[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  regfile[128];
  logic [7:0]  model_mem[128];
  logic        pend = 1'b0;
  logic [6:0]  pend_addr = 7'd0;

  // Register-file responder and bus observer.
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_we) begin
        got_wr.push_back({reg_addr, reg_wdata});
        regfile[reg_addr] = reg_wdata;
      end
      if (reg_re) begin
        got_rd.push_back(reg_addr);
        pend = 1'b1;
        pend_addr = reg_addr;
      end
      if (tx_valid && tx_ready) got_tx.push_back(tx_data);
      if (timeout_pulse) n_tmo++;
    end
  end

  always @(posedge clk) begin
    #1;
    reg_rdata = pend ? regfile[pend_addr] : 8'($urandom);
    pend = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic clear_obs();
    got_wr.delete(); got_rd.delete(); got_tx.delete();
    exp_wr.delete(); exp_rd.delete(); exp_tx.delete();
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] len;
    logic [7:0] d0;
    logic [7:0] d1;
    int         n_we;
    logic [6:0] a0;
    logic [6:0] a1;
    logic [7:0] w0;
    logic [7:0] w1;
  } vec_t;

  // Randomized transaction checked against address/length arithmetic over a memory image.
  task automatic run_txn(input logic [7:0] cmd, input int len);
    logic [7:0] data[4];
    logic [6:0] a;
    int         guard;
    int         low_run;
    clear_obs();
    for (int i = 0; i < len; i++) begin
      a = 7'((int'(cmd[6:0]) + (AUTO ? i : 0)) % 128);
      if (cmd[7]) begin
        data[i] = 8'($urandom);
        exp_wr.push_back({a, data[i]});
        model_mem[a] = data[i];
      end else begin
        exp_rd.push_back(a);
        exp_tx.push_back(model_mem[a]);
      end
    end
    send_byte(cmd);
    idle($urandom_range(0, 5));
    send_byte(8'(len));
    if (cmd[7]) begin
      for (int i = 0; i < len; i++) begin
        idle($urandom_range(0, 5));
        send_byte(data[i]);
      end
    end else if (len > 0) begin
      guard = 0;
      low_run = 0;
      while (got_tx.size() < len && guard < 300) begin
        tx_ready = (low_run >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
        low_run = tx_ready ? 0 : low_run + 1;
        rx_valid = ($urandom_range(0, 2) == 0);
        rx_data = 8'($urandom);
        tick();
        guard++;
      end
      rx_valid = 1'b0;
      tx_ready = 1'b0;
      if (guard >= 300) check("rnd_tx_budget", 32'(guard), 32'd0);
    end
    idle(3);
    check("rnd_busy", 32'(busy), 32'd0);
    check("rnd_wr_n", 32'(got_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++) check("rnd_wr", 32'(got_wr[i]), 32'(exp_wr[i]));
    check("rnd_rd_n", 32'(got_rd.size()), 32'(exp_rd.size()));
    for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++) check("rnd_rd", 32'(got_rd[i]), 32'(exp_rd[i]));
    check("rnd_tx_n", 32'(got_tx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++) check("rnd_tx", 32'(got_tx[i]), 32'(exp_tx[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    int   k;
    int   held;
    int   tmo_base;
    bit   found;

    vt[0] = '{8'h85, 8'h02, 8'hAA, 8'hBB, 2, 7'h05, AUTO ? 7'h06 : 7'h05, 8'hAA, 8'hBB};
    vt[1] = '{8'h83, 8'h00, 8'h00, 8'h00, 0, 7'h00, 7'h00, 8'h00, 8'h00};
    vt[2] = '{8'hFF, 8'h02, 8'h01, 8'h02, 2, 7'h7F, AUTO ? 7'h00 : 7'h7F, 8'h01, 8'h02};
    vt[3] = '{8'h03, 8'h00, 8'h00, 8'h00, 0, 7'h00, 7'h00, 8'h00, 8'h00};
    vt[4] = '{8'h8A, 8'h01, 8'h3C, 8'h00, 1, 7'h0A, 7'h00, 8'h3C, 8'h00};
    vt[5] = '{8'h80, 8'h02, 8'h11, 8'h22, 2, 7'h00, AUTO ? 7'h01 : 7'h00, 8'h11, 8'h22};

    for (int i = 0; i < 128; i++) regfile[i] = 8'($urandom);

    // Reset values
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_reg_we", 32'(reg_we), 32'd0);
    check("rst_reg_re", 32'(reg_re), 32'd0);
    check("rst_timeout", 32'(timeout_pulse), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_reg_wdata", 32'(reg_wdata), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_rx_ready", 32'(rx_ready), 32'd1);

    // Directed write / zero-length table
    for (int i = 0; i < 6; i++) begin
      clear_obs();
      send_byte(vt[i].cmd);
      send_byte(vt[i].len);
      if (vt[i].len > 0) send_byte(vt[i].d0);
      if (vt[i].len > 1) send_byte(vt[i].d1);
      check("tbl_busy_end", 32'(busy), 32'd0);
      idle(3);
      check("tbl_we_n", 32'(got_wr.size()), 32'(vt[i].n_we));
      check("tbl_re_n", 32'(got_rd.size()), 32'd0);
      if (vt[i].n_we > 0 && got_wr.size() > 0) check("tbl_wr0", 32'(got_wr[0]), 32'({vt[i].a0, vt[i].w0}));
      if (vt[i].n_we > 1 && got_wr.size() > 1) check("tbl_wr1", 32'(got_wr[1]), 32'({vt[i].a1, vt[i].w1}));
    end
    check("tbl_no_timeout", 32'(n_tmo), 32'd0);

    // Single read with TX backpressure
    clear_obs();
    regfile[7'h10] = 8'h5C;
    send_byte(8'h10);
    send_byte(8'h01);
    k = 0;
    while (!tx_valid && k < 10) begin tick(); k++; end
    check("rd_tx_valid_seen", 32'(tx_valid), 32'd1);
    held = 0;
    repeat (5) begin
      if (tx_valid && tx_data == 8'h5C) held++;
      tick();
    end
    check("rd_hold_5", 32'(held), 32'd5);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("rd_busy_drop", 32'(busy), 32'd0);
    check("rd_tx_valid_drop", 32'(tx_valid), 32'd0);
    check("rd_tx_n", 32'(got_tx.size()), 32'd1);
    if (got_tx.size() > 0) check("rd_tx_data", 32'(got_tx[0]), 32'h5C);
    check("rd_re_n", 32'(got_rd.size()), 32'd1);
    if (got_rd.size() > 0) check("rd_re_addr", 32'(got_rd[0]), 32'h10);

    // Timeout after a lone command byte, then a fresh command
    clear_obs();
    tmo_base = n_tmo;
    send_byte(8'h81);
    k = 0;
    found = 1'b0;
    while (!found && k < 40) begin
      tick();
      k++;
      if (timeout_pulse) found = 1'b1;
    end
    check("tmo_latency", 32'(k), 32'(TMO));
    check("tmo_busy", 32'(busy), 32'd0);
    tick();
    check("tmo_width", 32'(timeout_pulse), 32'd0);
    send_byte(8'h81);
    send_byte(8'h01);
    send_byte(8'h77);
    idle(3);
    check("tmo_pulse_count", 32'(n_tmo - tmo_base), 32'd1);
    check("tmo_new_we_n", 32'(got_wr.size()), 32'd1);
    if (got_wr.size() > 0) check("tmo_new_wr", 32'(got_wr[0]), 32'({7'h01, 8'h77}));

    // Handshake in the expiry cycle keeps the transaction
    clear_obs();
    tmo_base = n_tmo;
    send_byte(8'h81);
    idle(TMO - 1);
    send_byte(8'h01);
    check("race_busy", 32'(busy), 32'd1);
    send_byte(8'h42);
    idle(3);
    check("race_no_timeout", 32'(n_tmo - tmo_base), 32'd0);
    check("race_we_n", 32'(got_wr.size()), 32'd1);
    if (got_wr.size() > 0) check("race_wr", 32'(got_wr[0]), 32'({7'h01, 8'h42}));

    // Reset while waiting in RSEND
    clear_obs();
    tmo_base = n_tmo;
    send_byte(8'h10);
    send_byte(8'h02);
    k = 0;
    while (!tx_valid && k < 10) begin tick(); k++; end
    check("rstrd_in_rsend", 32'(tx_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("rstrd_tx_valid", 32'(tx_valid), 32'd0);
    check("rstrd_busy", 32'(busy), 32'd0);
    check("rstrd_timeout", 32'(timeout_pulse), 32'd0);
    rst = 1'b0;
    tx_ready = 1'b1;
    idle(25);
    tx_ready = 1'b0;
    check("rstrd_re_n", 32'(got_rd.size()), 32'd1);
    check("rstrd_tx_n", 32'(got_tx.size()), 32'd0);
    check("rstrd_no_pulse", 32'(n_tmo - tmo_base), 32'd0);

    // Randomized transactions
    for (int i = 0; i < 128; i++) begin
      regfile[i] = 8'($urandom);
      model_mem[i] = regfile[i];
    end
    tmo_base = n_tmo;
    for (int t = 0; t < 40; t++) begin
      logic [7:0] c;
      c = 8'($urandom);
      if (t % 8 == 3) c[6:0] = 7'h7E;
      run_txn(c, $urandom_range(0, 4));
    end
    check("rnd_no_timeout", 32'(n_tmo - tmo_base), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
